// File: rtl/prienc_pkg.sv
// Shared constants and width derivations for the prienc_scan priority encoder
// and its seven-segment display scanner.
package prienc_pkg;

    localparam int SEG_W = 8;

    // Segment pattern for hex digit 0; the display register resets to this.
    localparam logic [SEG_W-1:0] SEG_ZERO = 8'h3F;

    function automatic int idx_width(input int in_w);
        return $clog2(in_w);
    endfunction

    function automatic int digit_count(input int in_w);
        return (idx_width(in_w) + 3) / 4;
    endfunction

endpackage

// File: rtl/bcd7seg.sv
// Hex nibble to seven-segment decoder; pattern is {dp,g,f,e,d,c,b,a}, active-high.
module bcd7seg
    import prienc_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    // NOTE: the default arm assigns on every path, so no latch is inferred.
    always_comb begin
        case (nibble_i)
            4'h0:    seg_o = 8'h3F;
            4'h1:    seg_o = 8'h06;
            4'h2:    seg_o = 8'h5B;
            4'h3:    seg_o = 8'h4F;
            4'h4:    seg_o = 8'h66;
            4'h5:    seg_o = 8'h6D;
            4'h6:    seg_o = 8'h7D;
            4'h7:    seg_o = 8'h07;
            4'h8:    seg_o = 8'h7F;
            4'h9:    seg_o = 8'h6F;
            4'hA:    seg_o = 8'h77;
            4'hB:    seg_o = 8'h7C;
            4'hC:    seg_o = 8'h39;
            4'hD:    seg_o = 8'h5E;
            4'hE:    seg_o = 8'h79;
            default: seg_o = 8'h71;
        endcase
    end

endmodule

// File: rtl/prienc_scan.sv
// Registered priority encoder with a multiplexed hex display of the result.
// Define PRIENC_SCAN_LATCH_EN to make a valid result sticky until clr or reset.
module prienc_scan
    import prienc_pkg::*;
#(
    parameter  int IN_W     = 16,
    parameter  int SCAN_DIV = 50000,
    localparam int IDX_W    = idx_width(IN_W),
    localparam int DIGITS   = digit_count(IN_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   req_i,
    input  logic              en,
    input  logic              clr,
    output logic              indicator,
    output logic [IDX_W-1:0]  idx_o,
    output logic [SEG_W-1:0]  seg_o,
    output logic [DIGITS-1:0] an_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int EXT_W = 4 * DIGITS;

`ifdef PRIENC_SCAN_LATCH_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic [IDX_W-1:0]  idx_q, idx_d, enc_idx;
    logic              ind_q, ind_d, req_any;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [EXT_W-1:0]  idx_ext;
    logic [3:0]        nibble;
    logic              wrap;

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (req_i[i]) enc_idx = IDX_W'(i);
        end
    end

    assign req_any = |req_i;

    always_comb begin
        idx_d = idx_q;
        ind_d = ind_q;
        if (clr) begin
            idx_d = '0;
            ind_d = 1'b0;
        end else if (en && !(STICKY && ind_q)) begin
            idx_d = enc_idx;
            ind_d = req_any;
        end
    end

    always_comb begin
        wrap  = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        ptr_d = ptr_q;
        if (wrap) ptr_d = (ptr_q == PTR_W'(DIGITS - 1)) ? '0 : ptr_q + PTR_W'(1);
    end

    // Digit select and pattern are built from next-state values so the
    // display registers always agree with the registered index and pointer.
    always_comb begin
        idx_ext = EXT_W'(idx_d);
        nibble  = '0;
        an_d    = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (ptr_d == PTR_W'(d)) begin
                nibble  = idx_ext[4*d +: 4];
                an_d[d] = 1'b1;
            end
        end
    end

    bcd7seg u_bcd7seg (
        .nibble_i (nibble),
        .seg_o    (seg_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            ind_q <= 1'b0;
            cnt_q <= '0;
            ptr_q <= '0;
            an_q  <= DIGITS'(1);
            seg_q <= SEG_ZERO;
        end else begin
            idx_q <= idx_d;
            ind_q <= ind_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign idx_o     = idx_q;
    assign indicator = ind_q;
    assign an_o      = an_q;
    assign seg_o     = seg_q;

endmodule

// File: tb/tb_prienc_scan.sv
// Directed bench: a 16-bit encoder instance for the encode/clear/hold behaviour
// and a 256-bit instance holding index 8'hA3 for two-digit scanning.
module tb_prienc_scan;

`ifdef PRIENC_SCAN_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [15:0]  req16;
    logic         en16, clr16;
    logic         ind16;
    logic [3:0]   idx16;
    logic [7:0]   seg16;
    logic [0:0]   an16;
    logic [255:0] req256;
    logic         en256, clr256;
    logic         ind256;
    logic [7:0]   idx256;
    logic [7:0]   seg256;
    logic [1:0]   an256;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;

    prienc_scan #(.IN_W(16), .SCAN_DIV(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .req_i(req16), .en(en16), .clr(clr16),
        .indicator(ind16), .idx_o(idx16), .seg_o(seg16), .an_o(an16)
    );

    prienc_scan #(.IN_W(256), .SCAN_DIV(4)) dut256 (
        .clk(clk), .rst_n(rst_n), .req_i(req256), .en(en256), .clr(clr256),
        .indicator(ind256), .idx_o(idx256), .seg_o(seg256), .an_o(an256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
            4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
            4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
            4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k counts edges since reset release; digit pointer = (k/4) mod 2.
    task automatic check_scan256();
        logic ptr;
        ptr = ((k / 4) % 2) == 1;
        check($sformatf("scan256_idx_k%0d", k), 64'(idx256), 64'h A3);
        check($sformatf("scan256_ind_k%0d", k), 64'(ind256), 64'h1);
        check($sformatf("scan256_an_k%0d", k), 64'(an256), ptr ? 64'h2 : 64'h1);
        check($sformatf("scan256_seg_k%0d", k), 64'(seg256), ptr ? 64'h77 : 64'h4F);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
        check_scan256();
    endtask

    task automatic apply(input logic e, input logic c, input logic [15:0] r);
        en16  = e;
        clr16 = c;
        req16 = r;
        step();
    endtask

    task automatic check_res(input string tag, input logic [3:0] exp_idx, input logic exp_ind);
        check({tag, "_idx"}, 64'(idx16), 64'(exp_idx));
        check({tag, "_ind"}, 64'(ind16), 64'(exp_ind));
        check({tag, "_seg"}, 64'(seg16), 64'(seg_of(exp_idx)));
        check({tag, "_an"},  64'(an16),  64'h1);
    endtask

    task automatic check_all_reset(input string tag);
        check_res(tag, 4'h0, 1'b0);
        check({tag, "_idx256"}, 64'(idx256), 64'h0);
        check({tag, "_ind256"}, 64'(ind256), 64'h0);
        check({tag, "_an256"},  64'(an256),  64'h1);
        check({tag, "_seg256"}, 64'(seg256), 64'h3F);
    endtask

    initial begin
        rst_n  = 1'b0;
        en16   = 1'b0;
        clr16  = 1'b0;
        req16  = '0;
        en256  = 1'b1;
        clr256 = 1'b0;
        req256 = '0;
        req256[163] = 1'b1;
        req256[7]   = 1'b1;

        #12;
        check_all_reset("in_reset");

        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b0, 16'h0000); check_res("zero_req", 4'h0, 1'b0);
        apply(1'b1, 1'b0, 16'h0421); check_res("enc_0421", 4'hA, 1'b1);
        apply(1'b0, 1'b0, 16'h8000); check_res("hold_en0", 4'hA, 1'b1);
        apply(1'b1, 1'b0, 16'h8000); check_res("enc_8000", LATCH ? 4'hA : 4'hF, 1'b1);
        apply(1'b1, 1'b0, 16'h0000); check_res("enc_none", LATCH ? 4'hA : 4'h0, LATCH);
        apply(1'b1, 1'b1, 16'hFFFF); check_res("clr_over_en", 4'h0, 1'b0);
        apply(1'b1, 1'b0, 16'h0004); check_res("enc_0004", 4'h2, 1'b1);
        apply(1'b1, 1'b0, 16'h8000); check_res("enc_8000_b", LATCH ? 4'h2 : 4'hF, 1'b1);
        apply(1'b1, 1'b0, 16'h0001); check_res("enc_bit0", LATCH ? 4'h2 : 4'h0, 1'b1);
        apply(1'b1, 1'b1, 16'h8000); check_res("clr_again", 4'h0, 1'b0);
        apply(1'b1, 1'b0, 16'h8000); check_res("enc_after_clr", 4'hF, 1'b1);
        apply(1'b0, 1'b0, 16'h0000); check_res("hold_idle", 4'hF, 1'b1);

        // Advance into the second digit's window, then reset between edges.
        for (int i = 0; i < 8 && (k % 8) != 5; i++) step();
        check("mid_scan_window", 64'(an256), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_reset("async_reset");
        k = 0;

        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b0, 16'h0004); check_res("first_after_rst", 4'h2, 1'b1);
        for (int i = 0; i < 9; i++) step();
        check_res("hold_after_scan", 4'h2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prienc_scan.md
PRIENC_SCAN -- requirements
Module: prienc_scan

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, meaning request vector width (power of 2, 4..256).
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per display digit (>=2).
REQ-003 The block SHALL derive localparam IDX_W = clog2(IN_W) and DIGITS = ceil(IDX_W/4).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_i  input  IN_W  request bits; bit IN_W-1 has highest priority.
REQ-007 The block SHALL have port en  input  1  encode enable.
REQ-008 The block SHALL have port clr  input  1  synchronous clear of latched result.
REQ-009 The block SHALL have port indicator  output  1  registered: registered result is valid (some request seen).
REQ-010 The block SHALL have port idx_o  output  IDX_W  registered index of the highest set request bit.
REQ-011 The block SHALL have port seg_o  output  8  seven-segment pattern of the currently scanned hex digit.
REQ-012 The block SHALL have port an_o  output  DIGITS  one-hot, active-high digit select.

Function
REQ-013 Encode: when en=1 and req_i!=0, the block SHALL register idx_o = index of the most significant set bit and indicator=1 on the next edge (latency 1 cycle).
REQ-014 When en=1 and req_i==0, the block SHALL register idx_o=0 and indicator=0 (non-latch build).
REQ-015 When en=0, the block SHALL hold idx_o and indicator unchanged.
REQ-016 clr=1 SHALL force idx_o=0 and indicator=0 on the next edge, with priority over en.
REQ-017 Scan: a counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, the digit pointer SHALL advance by one, wrapping DIGITS-1 -> 0.
REQ-018 an_o SHALL equal the one-hot of the digit pointer; seg_o SHALL be the pattern of nibble [4*ptr+3:4*ptr] of idx_o zero-extended to 4*DIGITS bits.
REQ-019 seg_o and an_o SHALL change in the same cycle (registered together) so no digit ever shows another digit's pattern.
REQ-020 With DIGITS=1, the pointer SHALL stay 0 and an_o SHALL be constant 1.
REQ-021 Scan logic SHALL run independently of en and clr.

Reset
REQ-022 While rst_n=0, the block SHALL set idx_o=0, indicator=0, scan counter=0, pointer=0, an_o=one-hot bit 0, seg_o=pattern of digit 0.
REQ-023 Reset asserted mid-scan or mid-latch SHALL take effect immediately, without waiting for clk; the first edge after release SHALL behave as a normal cycle.

Configuration
REQ-024 Macro PRIENC_SCAN_LATCH_EN, when defined, SHALL make the result sticky: once indicator=1, further en cycles SHALL NOT update idx_o/indicator until clr or reset.
REQ-025 While latched with PRIENC_SCAN_LATCH_EN defined, clr=1 with en=1 and nonzero req_i SHALL clear, and the encode SHALL take effect on the following enabled cycle.
REQ-026 Without PRIENC_SCAN_LATCH_EN, the block SHALL behave per REQ-013..REQ-016 only.

Structure
REQ-027 A shared package prienc_pkg SHALL hold the IDX_W/DIGITS derivation functions and the seg pattern width constant (8).
REQ-028 The existing bcd7seg module SHALL be instantiated once as the only sub-module, fed by the selected 4-bit nibble.

Verification (IN_W=16, SCAN_DIV=4 unless noted)
REQ-029 Release reset, en=1, req_i=16'h0000 -> idx_o=0, indicator=0; an_o=1, seg_o=bcd7seg(0).
REQ-030 en=1, req_i=16'h0421 -> one cycle later idx_o=10, indicator=1; with en=0 and req_i=16'h8000, idx_o stays 10.
REQ-031 IN_W=256, idx_o=8'hA3 held -> an_o alternates 01/10 every 4 cycles with seg_o=bcd7seg(3)/bcd7seg(A) respectively.
REQ-032 clr=1 and en=1 with req_i=16'hFFFF in the same cycle -> idx_o=0, indicator=0 next cycle.
REQ-033 LATCH_EN build: req_i=16'h0004 then 16'h8000 with en=1 -> idx_o stays 2 until clr, then becomes 15.
REQ-034 Assert rst_n=0 between clock edges mid-scan -> all outputs at reset values before the next edge.
